vga_sprite_renderer: RTL

- Pixel-domain stage directly downstream of the CPU/VGA register-load interface.
- Captures the four sprite register words strobed out of the sprite RAM at screen begin (en[3:0] with reg_data), double-buffers them, and commits them atomically outside active video.
- Fetches one 16-pixel bitmap row per scan line during horizontal blank, then overlays a 16x16 single-colour sprite onto the background pixel stream with fixed 2-cycle latency.

---
 rtl/vga_sprite_renderer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_renderer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_sprite_renderer
//   Pixel-domain sprite stage. Captures the four sprite register words into a
//   shadow set and copies them all at once to the active set outside active
//   video. During horizontal blank it fetches the bitmap row for the next line,
//   then overlays a 16x16 single-colour sprite on the background pixel stream.
//   The fixed latency from h_cnt/bg_rgb to pix_rgb is 2 cycles.
//
// Ports
//   px_clk       pixel clock
//   rst          synchronous, active-high reset
//   reg_data     sprite register word
//   en[3:0]      load strobes: [0]=X, [1]=Y, [2]=colour, [3]=control
//   h_cnt/v_cnt  current pixel / line count
//   video_on     active-video qualifier for h_cnt/v_cnt
//   bg_rgb       background pixel, aligned with h_cnt
//   bitmap_data  bitmap ROM row word, valid 1 cycle after bitmap_addr
//   bitmap_addr  {index[3:0], row[3:0]} to the bitmap ROM
//   pix_rgb      composited pixel, 0 outside active video
//   sprite_hit   high when the sprite pixel is drawn
//   video_on_d   video_on delayed to line up with pix_rgb
//
// Fetch FSM
//   state   | meaning
//   IDLE    | waiting for h_cnt to reach the first blank pixel
//   CALC    | compute next-line row, issue ROM address or drop the line
//   WAIT    | ROM read latency
//   LATCH   | capture the row word into line_buf, mark line valid
// -----------------------------------------------------------------------------
module vga_sprite_renderer #(
  parameter int DATA_WIDTH = 16,
  parameter int H_WIDTH    = 10,
  parameter int V_WIDTH    = 10,
  parameter int H_FETCH    = 640,
  parameter int V_TOTAL    = 525
) (
  input  logic                  px_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic [3:0]            en,
  input  logic [H_WIDTH-1:0]    h_cnt,
  input  logic [V_WIDTH-1:0]    v_cnt,
  input  logic                  video_on,
  input  logic [11:0]           bg_rgb,
  input  logic [DATA_WIDTH-1:0] bitmap_data,
  output logic [7:0]            bitmap_addr,
  output logic [11:0]           pix_rgb,
  output logic                  sprite_hit,
  output logic                  video_on_d
);

  localparam logic [H_WIDTH-1:0] H_FETCH_C = H_WIDTH'(H_FETCH);
  localparam logic [V_WIDTH-1:0] V_LAST    = V_WIDTH'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } fetch_state_t;

  // Shadow set (written by en strobes) and active set (used for drawing)
  logic [H_WIDTH-1:0] sh_x,      act_x;
  logic [V_WIDTH-1:0] sh_y,      act_y;
  logic [11:0]        sh_colour, act_colour;
  logic               sh_enable, act_enable;
  logic               sh_hflip,  act_hflip;
  logic               sh_vflip,  act_vflip;
  logic [3:0]         sh_index,  act_index;
  logic               commit_pending;
  logic               commit;

  fetch_state_t       state_q, state_d;
  logic               addr_load, buf_load, line_clear;
  logic [15:0]        line_buf;
  logic               line_valid;

  logic [V_WIDTH-1:0] next_line;
  logic [V_WIDTH:0]   row_diff;
  logic               row_in_range;
  logic               fetch_hit;
  logic [3:0]         row_sel;

  logic [H_WIDTH:0]   col_diff;
  logic               col_in_range;
  logic               px_bit;
  logic               hit1;

  logic               s1_hit, s1_von;
  logic [11:0]        s1_colour, s1_bg;

  // Register bits with no function in this block
  logic               unused_reg_bits;
  assign unused_reg_bits = ^{reg_data[DATA_WIDTH-1:12], reg_data[3]};

  // ---------------------------------------------------------------------------
  // Register capture and atomic commit. The active set samples the shadow
  // before any same-cycle load, so a word landing on the commit cycle waits
  // for the next commit. A control write on the commit cycle re-arms
  // commit_pending so that word is not lost.
  // ---------------------------------------------------------------------------
  assign commit = commit_pending & ~video_on;

  always_ff @(posedge px_clk) begin
    if (rst) begin
      sh_x           <= '0;
      sh_y           <= '0;
      sh_colour      <= '0;
      sh_enable      <= 1'b0;
      sh_hflip       <= 1'b0;
      sh_vflip       <= 1'b0;
      sh_index       <= '0;
      act_x          <= '0;
      act_y          <= '0;
      act_colour     <= '0;
      act_enable     <= 1'b0;
      act_hflip      <= 1'b0;
      act_vflip      <= 1'b0;
      act_index      <= '0;
      commit_pending <= 1'b0;
    end else begin
      if (commit) begin
        act_x      <= sh_x;
        act_y      <= sh_y;
        act_colour <= sh_colour;
        act_enable <= sh_enable;
        act_hflip  <= sh_hflip;
        act_vflip  <= sh_vflip;
        act_index  <= sh_index;
      end
      if (en[0]) sh_x      <= reg_data[H_WIDTH-1:0];
      if (en[1]) sh_y      <= reg_data[V_WIDTH-1:0];
      if (en[2]) sh_colour <= reg_data[11:0];
      if (en[3]) begin
        sh_enable <= reg_data[0];
        sh_hflip  <= reg_data[1];
        sh_vflip  <= reg_data[2];
        sh_index  <= reg_data[7:4];
      end
      if (en[3])       commit_pending <= 1'b1;
      else if (commit) commit_pending <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-line bitmap fetch for the line after v_cnt. The subtraction is one bit
  // wider than v_cnt so lines above the sprite show up as a set MSB; the row is
  // in range only when every bit above bit 3 is clear.
  // ---------------------------------------------------------------------------
  assign next_line    = (v_cnt == V_LAST) ? '0 : v_cnt + V_WIDTH'(1);
  assign row_diff     = {1'b0, next_line} - {1'b0, act_y};
  assign row_in_range = (row_diff[V_WIDTH:4] == '0);
  assign fetch_hit    = act_enable & row_in_range;
  assign row_sel      = act_vflip ? ~row_diff[3:0] : row_diff[3:0];

  always_ff @(posedge px_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    addr_load  = 1'b0;
    buf_load   = 1'b0;
    line_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (h_cnt == H_FETCH_C) state_d = S_CALC;
      end
      S_CALC: begin
        if (fetch_hit) begin
          addr_load = 1'b1;
          state_d   = S_WAIT;
        end else begin
          line_clear = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        buf_load = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      bitmap_addr <= '0;
      line_buf    <= '0;
      line_valid  <= 1'b0;
    end else begin
      if (addr_load) bitmap_addr <= {act_index, row_sel};
      if (line_clear) line_valid <= 1'b0;
      if (buf_load) begin
        line_buf   <= bitmap_data[15:0];
        line_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline. Bit 15 of the row word is the leftmost pixel; hflip reads
  // the word from the other end. ~col[3:0] is 15-col.
  // ---------------------------------------------------------------------------
  assign col_diff     = {1'b0, h_cnt} - {1'b0, act_x};
  assign col_in_range = (col_diff[H_WIDTH:4] == '0);
  assign px_bit       = act_hflip ? line_buf[col_diff[3:0]] : line_buf[~col_diff[3:0]];
  assign hit1         = video_on & line_valid & col_in_range & px_bit;

  always_ff @(posedge px_clk) begin
    if (rst) begin
      s1_hit     <= 1'b0;
      s1_von     <= 1'b0;
      s1_colour  <= '0;
      s1_bg      <= '0;
      pix_rgb    <= '0;
      sprite_hit <= 1'b0;
      video_on_d <= 1'b0;
    end else begin
      s1_hit     <= hit1;
      s1_von     <= video_on;
      s1_colour  <= act_colour;
      s1_bg      <= bg_rgb;
      pix_rgb    <= !s1_von ? 12'h000 : (s1_hit ? s1_colour : s1_bg);
      sprite_hit <= s1_hit & s1_von;
      video_on_d <= s1_von;
    end
  end

endmodule
